tetris_move_sequencer: RTL and testbench
========================================

# tetris_move_sequencer

Consumes the one-cycle gravity tick from the 0.6 s divider and the one-cycle key pulses from the keyboard decoder. Owns the falling piece's origin (x, y) and rotation, and arbitrates gravity and player moves into one stream of candidate positions. Each candidate goes to the board collision checker over a valid/done handshake. On a failed downward move it emits a lock pulse to the board-merge stage, then spawns the next piece.

## Interface
- COLS, 10, board width; legal x is 0..COLS-1
- ROWS, 20, board height; legal y is 0..ROWS-1, y grows downward
- SPAWN_X, 4, spawn origin column
- SPAWN_Y, 0, spawn origin row

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- game_en  in  1  level; low forces IDLE
- tick  in  1  gravity pulse from divider; means down by one
- key_left, key_right, key_rot, key_down, key_drop  in  1 each  single-cycle key pulses
- req_valid  out  1  candidate position valid; held until chk_done
- req_x  out  4  candidate column
- req_y  out  5  candidate row
- req_rot  out  2  candidate rotation
- chk_done  in  1  checker result valid; honored only while req_valid=1
- chk_ok  in  1  candidate fits, qualified by chk_done
- piece_x  out  4  committed column
- piece_y  out  5  committed row
- piece_rot  out  2  committed rotation
- piece_valid  out  1  a live piece is on the board
- lock_valid  out  1  one-cycle pulse; piece_* is the final resting place
- game_over  out  1  sticky until rst

## Operation
- Pending register, 5 bits: HD (key_drop), ROT, L, R, DN (tick OR key_down).
  - A bit sets on its pulse in any state except IDLE and LOCK.
  - The bit chosen for issue clears when its request is issued.
  - If a bit's pulse arrives in the same cycle it is cleared, set wins.
  - All bits clear in IDLE and in LOCK.
- Issue priority: HD > ROT > L > R > DN. One request in flight at a time.
- Candidates:
  - L gives x-1. At x=0 the bit is dropped with no request.
  - R gives x+1. At x=COLS-1 the bit is dropped with no request.
  - ROT gives (rot+1) mod 4, wrapping 3 to 0.
  - DN gives y+1. At y=ROWS-1 it is treated as an immediate failure with no request.
- States:
  - IDLE: piece_valid=0. When game_en=1 and game_over=0, go to SPAWN.
  - SPAWN: load candidate (SPAWN_X, SPAWN_Y, 0) and raise req_valid, then go to WAIT.
  - READY: if any pending bit is set, pick the highest-priority bit and raise req_valid, then go to WAIT. Otherwise stay.
  - WAIT: hold req and the candidate stable until chk_done.
    - ok: commit the candidate to piece_*. If the request came from HD, go to HARD. Otherwise go to READY.
    - fail on spawn: set game_over and go to IDLE.
    - fail on DN or HD-down: go to LOCK.
    - fail on L, R or ROT: discard, go to READY.
  - HARD: issue y+1 (or fail immediately at y=ROWS-1), then go to WAIT. This repeats until a failure, which leads to LOCK.
  - LOCK: lock_valid=1 for this cycle only, then go to SPAWN.
- piece_valid=1 in READY, WAIT, HARD and LOCK, and while the SPAWN check is in flight after a piece has been committed.
- game_en low in any state:
  - next cycle: state is IDLE, req_valid=0 and pending is cleared;
  - piece_* holds its value and any in-flight result is ignored.
  - The checker must tolerate an abandoned request.

## Timing
- Reset values:
  - outputs: all 0; game_over=0;
  - internal: state IDLE, pending 0.
- A pulse sampled at edge n sets its pending bit, visible in cycle n+1. From READY, req_valid rises at edge n+2.
- req_x/y/rot are registered and change only on the edge that raises req_valid.
- chk_done sampled high at edge m:
  - req_valid=0 and piece_* is updated after edge m.
  - req_valid stays low for at least one cycle between requests, so the next request rises no earlier than edge m+2.
- Checker latency: at least 1 cycle after req_valid rises. chk_done in the same cycle req_valid rises is ignored.
- Lock: a failed down at edge m gives lock_valid high for cycle m+1. The spawn request rises at edge m+3.
- An immediate bound failure (no request issued) costs one cycle in place of the handshake.

## Test plan
- Spawn: rst, then game_en=1 with a checker that always returns ok after 2 cycles.
  - Expect req (4,0,0) and piece (4,0,0) with piece_valid=1.
  - Then one tick gives piece_y=1, committed 4 cycles after the tick edge.
- Priority: key_drop, key_rot and key_left pulse in the same cycle at (4,5,0), with ok up to y=9.
  - Expect the first req to be a down move (4,6,0), repeating to y=9.
  - Then lock_valid at (4,9,0), then spawn. ROT and L are discarded by the LOCK clear.
- Bounds: at x=0, key_left gives no req_valid and no change.
  - At rot=3, an accepted key_rot gives piece_rot=0.
  - At y=19, a tick gives lock_valid with no request issued.
- Rejected side move: key_right with chk_ok=0 leaves piece_* unchanged and lock_valid=0.
  - A tick arriving during that WAIT is issued next.
- Game over: the checker rejects the spawn position.
  - Expect game_over=1, state IDLE, no further requests even with game_en=1.
  - rst clears game_over.
- Abort: drop game_en mid-WAIT.
  - Expect req_valid=0 next cycle and a late chk_done ignored.
  - Re-enabling game_en causes a spawn.

Source files
------------

// File: rtl/tetris_move_sequencer.sv
// Falling-piece move sequencer: merges gravity ticks and key pulses into one stream
// of candidate positions, checks each with the board over valid/done, locks and respawns.
module tetris_move_sequencer #(
    parameter int COLS    = 10,
    parameter int ROWS    = 20,
    parameter int SPAWN_X = 4,
    parameter int SPAWN_Y = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       game_en,
    input  logic       tick,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_rot,
    input  logic       key_down,
    input  logic       key_drop,
    output logic       req_valid,
    output logic [3:0] req_x,
    output logic [4:0] req_y,
    output logic [1:0] req_rot,
    input  logic       chk_done,
    input  logic       chk_ok,
    output logic [3:0] piece_x,
    output logic [4:0] piece_y,
    output logic [1:0] piece_rot,
    output logic       piece_valid,
    output logic       lock_valid,
    output logic       game_over
);

    typedef enum logic [2:0] {
        S_IDLE, S_SPAWN, S_READY, S_WAIT, S_HARD, S_LOCK
    } state_t;

    typedef enum logic [2:0] {
        SRC_SPAWN, SRC_HD, SRC_ROT, SRC_L, SRC_R, SRC_DN
    } src_t;

    localparam int P_HD  = 4;
    localparam int P_ROT = 3;
    localparam int P_L   = 2;
    localparam int P_R   = 1;
    localparam int P_DN  = 0;

    localparam logic [3:0] X_MAX = 4'(COLS - 1);
    localparam logic [4:0] Y_MAX = 5'(ROWS - 1);

    state_t      r_state;
    src_t        r_src;
    logic [4:0]  r_pend;
    logic        r_arm;
    logic [3:0]  r_cand_x;
    logic [4:0]  r_cand_y;
    logic [1:0]  r_cand_rot;
    logic        r_cand_fail;
    logic        r_req_valid;
    logic [3:0]  r_req_x;
    logic [4:0]  r_req_y;
    logic [1:0]  r_req_rot;
    logic [3:0]  r_piece_x;
    logic [4:0]  r_piece_y;
    logic [1:0]  r_piece_rot;
    logic        r_piece_valid;
    logic        r_lock_valid;
    logic        r_game_over;

    logic [4:0]  w_sel_clr;
    src_t        w_sel_src;
    logic        w_sel_any;
    logic        w_sel_skip;
    logic        w_sel_fail;
    logic [3:0]  w_sel_x;
    logic [4:0]  w_sel_y;
    logic [1:0]  w_sel_rot;
    logic [4:0]  w_pend_set;
    logic [4:0]  w_pend_clr;
    logic [4:0]  w_pend_next;

    // Highest-priority pending move and its candidate; a blocked side move is just skipped.
    always_comb begin
        w_sel_clr  = '0;
        w_sel_src  = SRC_DN;
        w_sel_any  = |r_pend;
        w_sel_skip = 1'b0;
        w_sel_fail = 1'b0;
        w_sel_x    = r_piece_x;
        w_sel_y    = r_piece_y;
        w_sel_rot  = r_piece_rot;
        if (r_pend[P_HD]) begin
            w_sel_clr[P_HD] = 1'b1;
            w_sel_src       = SRC_HD;
            w_sel_fail      = (r_piece_y == Y_MAX);
            w_sel_y         = r_piece_y + 5'd1;
        end else if (r_pend[P_ROT]) begin
            w_sel_clr[P_ROT] = 1'b1;
            w_sel_src        = SRC_ROT;
            w_sel_rot        = r_piece_rot + 2'd1;
        end else if (r_pend[P_L]) begin
            w_sel_clr[P_L] = 1'b1;
            w_sel_src      = SRC_L;
            w_sel_skip     = (r_piece_x == 4'd0);
            w_sel_x        = r_piece_x - 4'd1;
        end else if (r_pend[P_R]) begin
            w_sel_clr[P_R] = 1'b1;
            w_sel_src      = SRC_R;
            w_sel_skip     = (r_piece_x == X_MAX);
            w_sel_x        = r_piece_x + 4'd1;
        end else if (r_pend[P_DN]) begin
            w_sel_clr[P_DN] = 1'b1;
            w_sel_src       = SRC_DN;
            w_sel_fail      = (r_piece_y == Y_MAX);
            w_sel_y         = r_piece_y + 5'd1;
        end
    end

    always_comb begin
        w_pend_set = {key_drop, key_rot, key_left, key_right, tick | key_down};
        w_pend_clr = (r_state == S_READY && !r_arm) ? w_sel_clr : 5'd0;
        if (!game_en || r_state == S_IDLE || r_state == S_LOCK) begin
            w_pend_next = '0;
        end else begin
            w_pend_next = (r_pend & ~w_pend_clr) | w_pend_set;
        end
    end

    // Every issue is two-step: latch the candidate (r_arm), then raise the request next edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_src         <= SRC_SPAWN;
            r_pend        <= '0;
            r_arm         <= 1'b0;
            r_cand_x      <= '0;
            r_cand_y      <= '0;
            r_cand_rot    <= '0;
            r_cand_fail   <= 1'b0;
            r_req_valid   <= 1'b0;
            r_req_x       <= '0;
            r_req_y       <= '0;
            r_req_rot     <= '0;
            r_piece_x     <= '0;
            r_piece_y     <= '0;
            r_piece_rot   <= '0;
            r_piece_valid <= 1'b0;
            r_lock_valid  <= 1'b0;
            r_game_over   <= 1'b0;
        end else begin
            r_pend <= w_pend_next;
            if (!game_en) begin
                r_state       <= S_IDLE;
                r_req_valid   <= 1'b0;
                r_arm         <= 1'b0;
                r_lock_valid  <= 1'b0;
                r_piece_valid <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_arm         <= 1'b0;
                        r_lock_valid  <= 1'b0;
                        r_piece_valid <= 1'b0;
                        if (!r_game_over) r_state <= S_SPAWN;
                    end
                    S_SPAWN: begin
                        if (!r_arm) begin
                            r_cand_x    <= 4'(SPAWN_X);
                            r_cand_y    <= 5'(SPAWN_Y);
                            r_cand_rot  <= 2'd0;
                            r_cand_fail <= 1'b0;
                            r_src       <= SRC_SPAWN;
                            r_arm       <= 1'b1;
                        end else begin
                            r_req_x     <= r_cand_x;
                            r_req_y     <= r_cand_y;
                            r_req_rot   <= r_cand_rot;
                            r_req_valid <= 1'b1;
                            r_arm       <= 1'b0;
                            r_state     <= S_WAIT;
                        end
                    end
                    S_READY, S_HARD: begin
                        if (r_arm) begin
                            r_arm <= 1'b0;
                            if (r_cand_fail) begin
                                r_lock_valid <= 1'b1;
                                r_state      <= S_LOCK;
                            end else begin
                                r_req_x     <= r_cand_x;
                                r_req_y     <= r_cand_y;
                                r_req_rot   <= r_cand_rot;
                                r_req_valid <= 1'b1;
                                r_state     <= S_WAIT;
                            end
                        end else if (r_state == S_HARD) begin
                            r_cand_x    <= r_piece_x;
                            r_cand_y    <= r_piece_y + 5'd1;
                            r_cand_rot  <= r_piece_rot;
                            r_cand_fail <= (r_piece_y == Y_MAX);
                            r_src       <= SRC_HD;
                            r_arm       <= 1'b1;
                        end else if (w_sel_any && !w_sel_skip) begin
                            r_cand_x    <= w_sel_x;
                            r_cand_y    <= w_sel_y;
                            r_cand_rot  <= w_sel_rot;
                            r_cand_fail <= w_sel_fail;
                            r_src       <= w_sel_src;
                            r_arm       <= 1'b1;
                        end
                    end
                    S_WAIT: begin
                        if (chk_done) begin
                            r_req_valid <= 1'b0;
                            if (chk_ok) begin
                                r_piece_x     <= r_req_x;
                                r_piece_y     <= r_req_y;
                                r_piece_rot   <= r_req_rot;
                                r_piece_valid <= 1'b1;
                                r_state       <= (r_src == SRC_HD) ? S_HARD : S_READY;
                            end else begin
                                case (r_src)
                                    SRC_SPAWN: begin
                                        r_game_over   <= 1'b1;
                                        r_piece_valid <= 1'b0;
                                        r_state       <= S_IDLE;
                                    end
                                    SRC_HD, SRC_DN: begin
                                        r_lock_valid <= 1'b1;
                                        r_state      <= S_LOCK;
                                    end
                                    default: r_state <= S_READY;
                                endcase
                            end
                        end
                    end
                    S_LOCK: begin
                        r_lock_valid <= 1'b0;
                        r_state      <= S_SPAWN;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign req_valid   = r_req_valid;
    assign req_x       = r_req_x;
    assign req_y       = r_req_y;
    assign req_rot     = r_req_rot;
    assign piece_x     = r_piece_x;
    assign piece_y     = r_piece_y;
    assign piece_rot   = r_piece_rot;
    assign piece_valid = r_piece_valid;
    assign lock_valid  = r_lock_valid;
    assign game_over   = r_game_over;

endmodule

// File: tb/tb_tetris_move_sequencer.sv
// Directed bench for tetris_move_sequencer: a model checker answers requests and a
// scoreboard of expected candidate positions is compared against issued requests.
module tb_tetris_move_sequencer;

    logic       clk = 1'b0;
    logic       rst, game_en, tick;
    logic       key_left, key_right, key_rot, key_down, key_drop;
    logic       req_valid, chk_done, chk_ok;
    logic [3:0] req_x, piece_x;
    logic [4:0] req_y, piece_y;
    logic [1:0] req_rot, piece_rot;
    logic       piece_valid, lock_valid, game_over;

    tetris_move_sequencer dut (
        .clk(clk), .rst(rst), .game_en(game_en), .tick(tick),
        .key_left(key_left), .key_right(key_right), .key_rot(key_rot),
        .key_down(key_down), .key_drop(key_drop),
        .req_valid(req_valid), .req_x(req_x), .req_y(req_y), .req_rot(req_rot),
        .chk_done(chk_done), .chk_ok(chk_ok),
        .piece_x(piece_x), .piece_y(piece_y), .piece_rot(piece_rot),
        .piece_valid(piece_valid), .lock_valid(lock_valid), .game_over(game_over)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Checker model controls (written only by the main block)
    bit resp_en    = 1'b1;
    bit reject_all = 1'b0;
    int ok_max_y   = 19;
    int fail_tokens = 0;
    bit man_done   = 1'b0;
    bit man_ok     = 1'b0;
    // Written only by the responder / monitor
    int fail_used  = 0;
    int wait_cnt   = 0;
    int lock_cnt   = 0;
    int obs_wr     = 0;
    logic [10:0] obs_mem [0:255];
    logic prev_req = 1'b0;

    typedef struct { int x; int y; int r; } req_t;
    req_t exp_q[$];
    int   obs_rd = 0;
    int   mx, my, mr;

    localparam int K_L = 0, K_R = 1, K_ROT = 2, K_DN = 3;

    // Model checker: answers 2 cycles after the request rises.
    always @(negedge clk) begin
        if (!resp_en) begin
            chk_done = man_done;
            chk_ok   = man_ok;
            wait_cnt = 0;
        end else begin
            chk_done = 1'b0;
            chk_ok   = 1'b0;
            if (req_valid) begin
                wait_cnt = wait_cnt + 1;
                if (wait_cnt >= 2) begin
                    chk_done = 1'b1;
                    chk_ok   = !reject_all && (int'(req_y) <= ok_max_y);
                    if (fail_used < fail_tokens) begin
                        chk_ok    = 1'b0;
                        fail_used = fail_used + 1;
                    end
                    wait_cnt = 0;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (req_valid && !prev_req) begin
            obs_mem[obs_wr[7:0]] = {req_x, req_y, req_rot};
            obs_wr = obs_wr + 1;
        end
        prev_req = req_valid;
        if (lock_valid) lock_cnt = lock_cnt + 1;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        assert (obs === exp) else begin
            n_err = n_err + 1;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int x, input int y, input int r);
        req_t e;
        e.x = x; e.y = y; e.r = r;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string tag);
        req_t e;
        logic [10:0] o;
        while (obs_rd < obs_wr) begin
            o = obs_mem[obs_rd[7:0]];
            obs_rd = obs_rd + 1;
            check({tag, "_req_expected"}, 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({tag, "_req_x"},   32'(o[10:7]), 32'(e.x));
                check({tag, "_req_y"},   32'(o[6:2]),  32'(e.y));
                check({tag, "_req_rot"}, 32'(o[1:0]),  32'(e.r));
            end
        end
        check({tag, "_req_missing"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_piece(input string tag);
        check({tag, "_x"},   32'(piece_x),   32'(mx));
        check({tag, "_y"},   32'(piece_y),   32'(my));
        check({tag, "_rot"}, 32'(piece_rot), 32'(mr));
    endtask

    task automatic pulse(input bit l, input bit r, input bit ro, input bit dr, input bit tk);
        @(negedge clk);
        key_left = l; key_right = r; key_rot = ro; key_drop = dr; tick = tk;
        @(negedge clk);
        key_left = 0; key_right = 0; key_rot = 0; key_drop = 0; tick = 0;
    endtask

    task automatic wait_sig(input string tag, input int which, input int max_cyc);
        int n;
        logic s;
        n = 0;
        s = 1'b0;
        while (n < max_cyc) begin
            @(negedge clk);
            s = (which == 0) ? lock_valid : (which == 1) ? piece_valid :
                (which == 2) ? game_over  : req_valid;
            if (s) break;
            n++;
        end
        check({tag, "_seen"}, 32'(s), 32'd1);
    endtask

    task automatic move(input string tag, input int kind, input bit accept);
        int cx, cy, cr;
        bit reqd;
        cx = mx; cy = my; cr = mr; reqd = 1'b1;
        case (kind)
            K_L:     if (mx == 0) reqd = 1'b0; else cx = mx - 1;
            K_R:     if (mx == 9) reqd = 1'b0; else cx = mx + 1;
            K_ROT:   cr = (mr + 1) % 4;
            default: cy = my + 1;
        endcase
        if (reqd) begin
            push(cx, cy, cr);
            if (!accept) fail_tokens = fail_tokens + 1;
        end
        pulse(kind == K_L, kind == K_R, kind == K_ROT, 1'b0, kind == K_DN);
        repeat (8) @(negedge clk);
        if (reqd && accept) begin mx = cx; my = cy; mr = cr; end
        drain(tag);
        check_piece(tag);
    endtask

    initial begin
        int l0;
        rst = 1; game_en = 0; tick = 0;
        key_left = 0; key_right = 0; key_rot = 0; key_down = 0; key_drop = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        mx = 0; my = 0; mr = 0;
        check("rst_req_valid", 32'(req_valid), 0);
        check("rst_piece_valid", 32'(piece_valid), 0);
        check("rst_lock", 32'(lock_valid), 0);
        check("rst_game_over", 32'(game_over), 0);
        check_piece("rst_piece");

        // Spawn, then gravity tick latency
        push(4, 0, 0);
        game_en = 1;
        wait_sig("spawn_commit", 1, 20);
        mx = 4; my = 0; mr = 0;
        check_piece("spawn_piece");
        drain("spawn");
        push(4, 1, 0);
        tick = 1;
        @(negedge clk); tick = 0;
        @(negedge clk); check("tick_req_n1", 32'(req_valid), 0);
        @(negedge clk); check("tick_req_n2", 32'(req_valid), 1);
        @(negedge clk); check("tick_y_n3", 32'(piece_y), 0);
        @(negedge clk); check("tick_y_n4", 32'(piece_y), 1);
        my = 1;
        drain("tick");
        for (int i = 0; i < 4; i++) move("fall", K_DN, 1'b1);

        // Drop + rot + left together at (4,5,0): drop wins, lands at y=9
        ok_max_y = 9;
        for (int y = 6; y <= 10; y++) push(4, y, 0);
        push(4, 0, 0);
        l0 = lock_cnt;
        pulse(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        wait_sig("prio_lock", 0, 80);
        my = 9;
        check_piece("prio_lock_piece");
        @(negedge clk);
        check("prio_lock_1cyc", 32'(lock_valid), 0);
        check("prio_spawn_m1", 32'(req_valid), 0);
        @(negedge clk); check("prio_spawn_m2", 32'(req_valid), 0);
        @(negedge clk); check("prio_spawn_m3", 32'(req_valid), 1);
        repeat (8) @(negedge clk);
        ok_max_y = 19;
        my = 0;
        check_piece("prio_respawn");
        check("prio_lock_count", 32'(lock_cnt - l0), 1);
        drain("prio");

        // Bounds: left wall, rotation wrap, floor by tick
        for (int i = 0; i < 4; i++) move("left", K_L, 1'b1);
        move("left_wall", K_L, 1'b1);
        for (int i = 0; i < 4; i++) move("rot", K_ROT, 1'b1);
        for (int i = 0; i < 19; i++) move("sink", K_DN, 1'b1);
        push(4, 0, 0);
        l0 = lock_cnt;
        pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_sig("floor_lock", 0, 20);
        check_piece("floor_piece");
        repeat (8) @(negedge clk);
        check("floor_lock_count", 32'(lock_cnt - l0), 1);
        mx = 4; my = 0; mr = 0;
        check_piece("floor_respawn");
        drain("floor");

        // Hard drop all the way to the floor
        for (int y = 1; y <= 19; y++) push(4, y, 0);
        push(4, 0, 0);
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_sig("hd_lock", 0, 200);
        my = 19;
        check_piece("hd_piece");
        repeat (8) @(negedge clk);
        my = 0;
        check_piece("hd_respawn");
        drain("hd");

        // Rejected right; tick arriving during its WAIT goes next
        l0 = lock_cnt;
        push(5, 0, 0);
        fail_tokens = fail_tokens + 1;
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        push(4, 1, 0);
        tick = 1;
        @(negedge clk); tick = 0;
        @(negedge clk);
        check("rej_req_dropped", 32'(req_valid), 0);
        check_piece("rej_piece_held");
        repeat (10) @(negedge clk);
        my = 1;
        check_piece("rej_then_tick");
        check("rej_no_lock", 32'(lock_cnt - l0), 0);
        drain("rej");

        // Game over: every position rejected
        reject_all = 1;
        l0 = lock_cnt;
        push(4, 2, 0);
        push(4, 0, 0);
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_sig("gameover", 2, 60);
        repeat (20) @(negedge clk);
        check("go_sticky", 32'(game_over), 1);
        check("go_req_idle", 32'(req_valid), 0);
        check("go_piece_valid", 32'(piece_valid), 0);
        check("go_lock_count", 32'(lock_cnt - l0), 1);
        check_piece("go_piece_held");
        drain("go");
        rst = 1; game_en = 0; reject_all = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk);
        mx = 0; my = 0; mr = 0;
        check("go_rst_clear", 32'(game_over), 0);
        check_piece("go_rst_piece");

        // Abort mid-WAIT, late done ignored, re-enable respawns
        resp_en = 0;
        push(4, 0, 0);
        game_en = 1;
        wait_sig("abort_req", 3, 20);
        @(negedge clk);
        game_en = 0;
        @(negedge clk);
        check("abort_req_drop", 32'(req_valid), 0);
        man_done = 1; man_ok = 1;
        @(negedge clk);
        man_done = 0; man_ok = 0;
        @(negedge clk);
        check("abort_piece_valid", 32'(piece_valid), 0);
        check_piece("abort_late_done");
        drain("abort");
        resp_en = 1;
        push(4, 0, 0);
        game_en = 1;
        wait_sig("reenable", 1, 20);
        mx = 4;
        check_piece("reenable_piece");
        repeat (4) @(negedge clk);
        drain("reenable");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
